data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Two-master arbiter that shares the single-port data memory between the CPU (master 0) and a secondary bus master (master 1, e.g. loader or display fetch). It sits between the masters and the memory-mapped data memory. It grants at most one access per cycle and gives master 0 priority. An aging counter bounds master 1's wait, and a lock input lets master 1 run back-to-back bursts. Read data returns one cycle after grant, matching the memory's synchronous read.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `MAX_WAIT`, 4, consecutive denied cycles after which master 1 wins (range 1..15)
- `MAX_LOCK`, 8, maximum consecutive grants to master 1 under lock (range 1..15)

Ports:
- `clock`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `m0_req`, `m1_req`  in  1  access request, held until granted
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_addr`, `m1_addr`  in  ADDR_W  address
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data
- `m1_lock`  in  1  master 1 requests to keep ownership for its next request
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle (combinational)
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid (registered)
- `m0_rdata`, `m1_rdata`  out  DATA_W  read data (valid only with rvalid)
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, one cycle after address

## Operation
- States: `IDLE`, `OWN0`, `OWN1`, `LOCK1`. The state is the owner of the last granted cycle.
- Winner rule, evaluated each cycle:
  1. If state is `LOCK1` and `m1_req`: master 1 wins.
  2. Else if `m1_req` and `wait_cnt == MAX_WAIT`: master 1 wins.
  3. Else if `m0_req`: master 0 wins.
  4. Else if `m1_req`: master 1 wins.
  5. Else: no grant.
- Winner gets `gnt=1`. Its `we`, `addr` and `wdata` drive the memory outputs combinationally.
- With no grant: `mem_we=0`, `mem_addr=0`, `mem_wdata=0`. A loser's `we` never reaches the memory.
- `wait_cnt` (4 bits):
  - increments when `m1_req` is high and master 1 loses, saturating at `MAX_WAIT`;
  - clears when master 1 is granted or `m1_req` is low.
- Transitions:
  - grant to master 0 → `OWN0`;
  - grant to master 1 with `m1_lock=1` and `lock_cnt < MAX_LOCK-1` → `LOCK1`;
  - grant to master 1 otherwise → `OWN1`;
  - no grant → `IDLE`.
- `lock_cnt`: increments on each `LOCK1` grant and clears on leaving `LOCK1`. On reaching `MAX_LOCK-1` the next master-1 grant goes to `OWN1`, so a lock burst is at most `MAX_LOCK` grants.
- `LOCK1` with `m1_req=0`: lock releases, normal rules apply, next state follows the grant.
- Read return:
  - a registered read tag (`none`/`m0`/`m1`) is set on a read grant;
  - next cycle the tagged `rvalid` is 1 and `mem_rdata` routes to that master's `rdata`;
  - writes never produce `rvalid`;
  - `rdata` of the untagged master is 0.

## Timing
- Grant: zero latency, in the same cycle as `req` when the master wins.
- Read data: `rvalid` exactly one cycle after a read grant. Back-to-back reads give `rvalid` every cycle, alternating masters if grants alternate.
- Write: completes at the clock edge ending the granted cycle.
- Worst-case master 1 wait with `m0_req` held continuously is `MAX_WAIT` cycles. Grant comes on cycle `MAX_WAIT+1`.
- Master 0 wait is bounded by `MAX_LOCK` (lock burst), or 1 (aging win).
- Reset (`reset=0`, asynchronous):
  - state `IDLE`, `wait_cnt=0`, `lock_cnt=0`, read tag `none`;
  - all `gnt`, `rvalid` and `mem_we` are 0; `rdata` 0.
  - Gnt is forced 0 while reset is asserted.
  - A read granted in the cycle reset asserts never returns `rvalid`.
- Reset release: the first edge after `reset` rises may grant.
- Simultaneous `m0_req` and `m1_req` with `wait_cnt < MAX_WAIT` in a non-lock state: master 0 wins.

## Structure
- Package `data_memory_arbiter_pkg`:
  - state enum (`IDLE`, `OWN0`, `OWN1`, `LOCK1`);
  - read tag enum (`TAG_NONE`, `TAG_M0`, `TAG_M1`);
  - counter width constant (4).
- Single module, no sub-module. The winner select is one combinational block. State, counters and the tag are one sequential block.

## Test plan
- Reset mid-read: grant `m0` read of address 0x0010, assert `reset=0` in the same cycle → no `m0_rvalid` follows. All outputs are 0 while reset is low.
- Master 0 alone: read 0x0004 with memory holding 0x1234 → `m0_gnt` in cycle N; `m0_rvalid=1` and `m0_rdata=0x1234` in N+1; `m1_rvalid` stays 0.
- Contention/aging: `m0_req` and `m1_req` held high, `MAX_WAIT=4` → `m0` granted in cycles 1–4, `m1` granted in cycle 5, then `wait_cnt` returns to 0 and `m0` wins cycle 6.
- Lock burst: `m1_req` and `m1_lock` high, `m0_req` high, `MAX_LOCK=8` → 8 consecutive `m1` grants, then `m0` granted.
- Writes: `m1` writes 0xBEEF to 0x0020 while `m0` idle → `mem_we=1` and `mem_addr=0x0020` in the grant cycle; no `rvalid`. A following `m0` read of 0x0020 returns 0xBEEF.
- Alternating reads: `m0` reads 0x0001 and `m1` reads 0x0002 back-to-back → each `rvalid` appears on the correct master one cycle after its own grant, with the correct data.

Source files
------------

// File: rtl/data_memory_arbiter_pkg.sv
// Shared types for the two-master data memory arbiter: owner states,
// read-return tags and the width of the aging/lock counters.
package data_memory_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1,
    LOCK1
  } arb_state_e;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_M0,
    TAG_M1
  } rd_tag_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/data_memory_arbiter.sv
// Shares one single-port synchronous data memory between the CPU (master 0,
// priority) and a secondary master 1 with aging and lock-burst support.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] WAIT_LIM  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

  arb_state_e       state_q, state_d;
  rd_tag_e          tag_q, tag_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  logic lock_hold;
  logic aged;
  logic m0_win;
  logic m1_win;

  // Winner select and memory-side mux; reset low suppresses every grant so a
  // request caught by an asserting reset never reaches the memory.
  always_comb begin
    lock_hold = (state_q == LOCK1) && m1_req;
    aged      = m1_req && (wait_cnt_q == WAIT_LIM);
    m1_win    = reset && (lock_hold || aged || (m1_req && !m0_req));
    m0_win    = reset && m0_req && !m1_win;

    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_win) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_win) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  assign m0_gnt = m0_win;
  assign m1_gnt = m1_win;

  always_comb begin
    state_d    = IDLE;
    tag_d      = TAG_NONE;
    lock_cnt_d = '0;
    wait_cnt_d = '0;

    if (m0_win) begin
      state_d = OWN0;
      if (!m0_we) tag_d = TAG_M0;
    end else if (m1_win) begin
      // lock_cnt is zero outside LOCK1, so a fresh burst starts counting at 0
      if (m1_lock && (lock_cnt_q < LOCK_LAST)) begin
        state_d    = LOCK1;
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end else begin
        state_d = OWN1;
      end
      if (!m1_we) tag_d = TAG_M1;
    end

    if (m1_req && !m1_win) wait_cnt_d = sat_inc(wait_cnt_q, WAIT_LIM);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tag_q      <= TAG_NONE;
      wait_cnt_q <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      wait_cnt_q <= wait_cnt_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Memory data arrives one cycle after its address; the tag steers it.
  assign m0_rvalid = (tag_q == TAG_M0);
  assign m1_rvalid = (tag_q == TAG_M1);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench: stimulus checks grants and queues expected read returns;
// a negedge monitor pops and compares them when rvalid appears.
module tb_data_memory_arbiter;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 4;
  localparam int MAX_LOCK = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              m0_req = 1'b0, m0_we = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0;
  logic              m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [DATA_W-1:0] m1_wdata = '0;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
  logic [DATA_W-1:0] m0_rdata, m1_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic              who;
    logic [DATA_W-1:0] data;
    int                due;
  } rd_exp_t;
  rd_exp_t exp_q[$];
  rd_exp_t mon_e;

  data_memory_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] init_val(input logic [7:0] a);
    case (a)
      8'h01:   return 16'hA001;
      8'h02:   return 16'hB002;
      8'h04:   return 16'h1234;
      8'h10:   return 16'h0C10;
      default: return 16'h0000;
    endcase
  endfunction

  // Synchronous single-port memory model, reloaded while reset is low.
  logic [DATA_W-1:0] mem [0:255];
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      chk("rvalid_m0", 32'(m0_rvalid), 32'(!mon_e.who));
      chk("rvalid_m1", 32'(m1_rvalid), 32'(mon_e.who));
      chk("rdata", 32'(mon_e.who ? m1_rdata : m0_rdata), 32'(mon_e.data));
      chk("rdata_other", 32'(mon_e.who ? m0_rdata : m1_rdata), 32'h0);
      $display("read return m%0d data=%h", mon_e.who, mon_e.who ? m1_rdata : m0_rdata);
    end else if (m0_rvalid || m1_rvalid) begin
      chk("rvalid_spurious", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic [15:0] a0,
                       input logic [15:0] d0, input logic r1, input logic w1,
                       input logic [15:0] a1, input logic [15:0] d1, input logic l1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_lock = l1;
  endtask

  // Checks one cycle's grant and memory drive, queues the read return, then
  // advances to just after the next rising edge.
  task automatic cyc_check(input string name, input logic e0, input logic e1,
                           input logic e_we, input logic [15:0] e_addr,
                           input logic [15:0] e_wd, input logic [15:0] e_rd);
    @(negedge clock);
    chk({name, "_m0_gnt"}, 32'(m0_gnt), 32'(e0));
    chk({name, "_m1_gnt"}, 32'(m1_gnt), 32'(e1));
    chk({name, "_mem_we"}, 32'(mem_we), 32'(e_we));
    chk({name, "_mem_addr"}, 32'(mem_addr), 32'(e_addr));
    chk({name, "_mem_wdata"}, 32'(mem_wdata), 32'(e_wd));
    $display("cycle %0d %s gnt0=%0d gnt1=%0d we=%0d addr=%h", cyc, name, m0_gnt, m1_gnt,
             mem_we, mem_addr);
    if ((e0 || e1) && !e_we) exp_q.push_back('{who: e1, data: e_rd, due: cyc + 1});
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_m0_gnt"}, 32'(m0_gnt), 32'h0);
    chk({name, "_m1_gnt"}, 32'(m1_gnt), 32'h0);
    chk({name, "_rvalid"}, {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
    chk({name, "_rdata"}, {m0_rdata, m1_rdata}, 32'h0);
    chk({name, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({name, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({name, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held low with a pending request: nothing may be granted.
    @(posedge clock); #1;
    drive(1, 0, 16'h0010, 0, 1, 0, 16'h0002, 0, 0);
    @(negedge clock);
    check_all_zero("in_reset");
    @(posedge clock); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Reset asserting during a granted read: no rvalid may follow.
    drive(1, 0, 16'h0010, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("rst_mid_read_pre_gnt", 32'(m0_gnt), 32'h1);
    #2 reset = 1'b0;
    #1 check_all_zero("rst_mid_read_asserted");
    @(posedge clock); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    check_all_zero("rst_mid_read_after");
    @(posedge clock); #1;
    reset = 1'b1;

    // Master 0 alone.
    drive(1, 0, 16'h0004, 0, 0, 0, 0, 0, 0);
    cyc_check("m0_alone", 1, 0, 0, 16'h0004, 0, 16'h1234);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc_check("idle_a", 0, 0, 0, 0, 0, 0);

    // Contention with aging: m0 x4, m1 on the fifth, then m0 again.
    drive(1, 0, 16'h0004, 0, 1, 0, 16'h0002, 0, 0);
    for (int i = 1; i <= MAX_WAIT; i++) cyc_check("age_m0", 1, 0, 0, 16'h0004, 0, 16'h1234);
    cyc_check("age_m1", 0, 1, 0, 16'h0002, 0, 16'hB002);
    cyc_check("age_m0_after", 1, 0, 0, 16'h0004, 0, 16'h1234);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc_check("idle_b", 0, 0, 0, 0, 0, 0);

    // Lock burst: aging win starts an 8-grant burst, then m0 regains the bus.
    drive(1, 0, 16'h0004, 0, 1, 0, 16'h0002, 0, 1);
    for (int i = 1; i <= MAX_WAIT; i++) cyc_check("lock_pre_m0", 1, 0, 0, 16'h0004, 0, 16'h1234);
    for (int i = 1; i <= MAX_LOCK; i++) cyc_check("lock_m1", 0, 1, 0, 16'h0002, 0, 16'hB002);
    cyc_check("lock_end_m0", 1, 0, 0, 16'h0004, 0, 16'h1234);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc_check("idle_c", 0, 0, 0, 0, 0, 0);

    // Writes and a read-back.
    drive(0, 0, 0, 0, 1, 1, 16'h0020, 16'hBEEF, 0);
    cyc_check("m1_write", 0, 1, 1, 16'h0020, 16'hBEEF, 0);
    drive(1, 0, 16'h0020, 0, 0, 0, 0, 0, 0);
    cyc_check("m0_readback", 1, 0, 0, 16'h0020, 0, 16'hBEEF);

    // Losing writer must not reach the memory.
    drive(1, 0, 16'h0001, 0, 1, 1, 16'h0030, 16'h5555, 0);
    cyc_check("loser_write", 1, 0, 0, 16'h0001, 0, 16'hA001);
    drive(0, 0, 0, 0, 1, 1, 16'h0030, 16'h5555, 0);
    cyc_check("m1_write2", 0, 1, 1, 16'h0030, 16'h5555, 0);
    drive(1, 0, 16'h0030, 0, 0, 0, 0, 0, 0);
    cyc_check("m0_readback2", 1, 0, 0, 16'h0030, 0, 16'h5555);

    // Alternating back-to-back reads.
    drive(1, 0, 16'h0001, 0, 0, 0, 0, 0, 0);
    cyc_check("alt_m0_a", 1, 0, 0, 16'h0001, 0, 16'hA001);
    drive(0, 0, 0, 0, 1, 0, 16'h0002, 0, 0);
    cyc_check("alt_m1_a", 0, 1, 0, 16'h0002, 0, 16'hB002);
    drive(1, 0, 16'h0004, 0, 0, 0, 0, 0, 0);
    cyc_check("alt_m0_b", 1, 0, 0, 16'h0004, 0, 16'h1234);
    drive(0, 0, 0, 0, 1, 0, 16'h0020, 0, 0);
    cyc_check("alt_m1_b", 0, 1, 0, 16'h0020, 0, 16'hBEEF);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc_check("idle_end", 0, 0, 0, 0, 0, 0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
